// File: rtl/rc4_mem_pkg.sv
// Shared types and constants for the RC4 memory handler.
package rc4_mem_pkg;

    // Memory selector carried on each client's memory_sel lines
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_S    = 2'd1,
        SEL_ROM  = 2'd2,
        SEL_OUT  = 2'd3
    } mem_sel_t;

    // Handler FSM states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OWNED   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Depth of the message ROM and the decrypted-output RAM
    localparam int MSG_DEPTH = 32;

endpackage

// File: rtl/fixed_prio_arb.sv
// Combinational fixed-priority picker: the lowest set request index wins.
module fixed_prio_arb #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    logic found;

    // Walk from index 0 upward and keep only the first request seen
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rc4_mem_handler.sv
// Responder for the RC4 client memory interface: grants exclusive ownership
// to one client FSM at a time and routes its accesses to S RAM, message ROM
// and output RAM, returning read data on a shared bus.
module rc4_mem_handler #(
    parameter int NUM_CLIENTS = 3,
    parameter int MSG_DEPTH   = rc4_mem_pkg::MSG_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CLIENTS-1:0]   req_own,
    input  logic [2*NUM_CLIENTS-1:0] req_sel,
    input  logic [8*NUM_CLIENTS-1:0] req_addr,
    input  logic [8*NUM_CLIENTS-1:0] req_wdata,
    input  logic [NUM_CLIENTS-1:0]   req_wen,
    output logic [NUM_CLIENTS-1:0]   grant,
    output logic [7:0]               q_data,
    output logic                     busy,
    output logic                     err,
    output logic [7:0]               s_addr,
    output logic [7:0]               s_wdata,
    output logic                     s_wen,
    input  logic [7:0]               s_q,
    output logic [4:0]               rom_addr,
    input  logic [7:0]               rom_q,
    output logic [4:0]               out_addr,
    output logic [7:0]               out_wdata,
    output logic                     out_wen
);
    import rc4_mem_pkg::*;

    logic [1:0]             state;
    logic [NUM_CLIENTS-1:0] pick;
    mem_sel_t               sel_d;
    mem_sel_t               o_sel;
    logic [7:0]             o_addr;
    logic [7:0]             o_wdata;
    logic                   o_wen;
    logic                   active;
    logic                   bad_addr;
    logic                   intruder;
    logic                   viol;

    fixed_prio_arb #(.N(NUM_CLIENTS)) u_arb (
        .req (req_own),
        .gnt (pick)
    );

    // Select the current owner's request lines (grant is one-hot or zero)
    always_comb begin
        o_sel   = SEL_NONE;
        o_addr  = '0;
        o_wdata = '0;
        o_wen   = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant[i]) begin
                o_sel   = mem_sel_t'(req_sel[2*i +: 2]);
                o_addr  = req_addr[8*i +: 8];
                o_wdata = req_wdata[8*i +: 8];
                o_wen   = req_wen[i];
            end
        end
    end

    // Reset gates routing so nothing is written in the reset cycle
    assign active   = (state == ST_OWNED) && !reset;
    assign bad_addr = ((o_sel == SEL_ROM) || (o_sel == SEL_OUT)) && (int'(o_addr) >= MSG_DEPTH);
    assign intruder = |(req_wen & ~grant);
    assign viol     = active && (((o_sel == SEL_ROM) && o_wen) || bad_addr || intruder);

    // Route the owner's access to the selected memory; others see zeros
    always_comb begin
        s_addr    = '0;
        s_wdata   = '0;
        s_wen     = 1'b0;
        rom_addr  = '0;
        out_addr  = '0;
        out_wdata = '0;
        out_wen   = 1'b0;
        if (active) begin
            case (o_sel)
                SEL_S: begin
                    s_addr  = o_addr;
                    s_wdata = o_wdata;
                    s_wen   = o_wen;
                end
                SEL_ROM: begin
                    if (!bad_addr) rom_addr = o_addr[4:0];
                end
                SEL_OUT: begin
                    if (!bad_addr) begin
                        out_addr  = o_addr[4:0];
                        out_wdata = o_wdata;
                        out_wen   = o_wen;
                    end
                end
                default: ;
            endcase
        end
    end

    // Ownership FSM: grant on request, hold until owner drops, one quiet cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            grant <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_own) begin
                        state <= ST_OWNED;
                        grant <= pick;
                        busy  <= 1'b1;
                    end
                end
                ST_OWNED: begin
                    if (!(|(req_own & grant))) begin
                        state <= ST_RELEASE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Remember which memory was read so the return mux lines up with 1-cycle RAM/ROM latency
    always_ff @(posedge clk) begin
        if (reset)
            sel_d <= SEL_NONE;
        else if (active && !bad_addr)
            sel_d <= o_sel;
        else
            sel_d <= SEL_NONE;
    end

    // Sticky protocol-violation flag
    always_ff @(posedge clk) begin
        if (reset)
            err <= 1'b0;
        else if (viol)
            err <= 1'b1;
    end

    // Read return mux; output RAM is write-only so it returns 0
    always_comb begin
        case (sel_d)
            SEL_S:   q_data = s_q;
            SEL_ROM: q_data = rom_q;
            default: q_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_rc4_mem_handler.sv
// Directed bench for rc4_mem_handler with a behavioural ownership model
// checked every cycle plus hand-computed literal expectations.
module tb_rc4_mem_handler;
    localparam int NC = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [NC-1:0]   req_own, req_wen;
    logic [2*NC-1:0] req_sel;
    logic [8*NC-1:0] req_addr, req_wdata;
    logic [NC-1:0]   grant;
    logic [7:0]      q_data;
    logic            busy, err;
    logic [7:0]      s_addr, s_wdata, s_q;
    logic            s_wen;
    logic [4:0]      rom_addr, out_addr;
    logic [7:0]      rom_q, out_wdata;
    logic            out_wen;

    logic [7:0] s_mem [256];
    logic [7:0] out_mem [32];

    int n_vec  = 0;
    int n_miss = 0;

    // model state
    int         m_owner = -1;
    int         m_gap   = 0;
    bit         m_err   = 1'b0;
    logic [1:0] m_seld  = 2'd0;

    always #5 clk = ~clk;

    rc4_mem_handler #(.NUM_CLIENTS(NC)) dut (
        .clk(clk), .reset(reset),
        .req_own(req_own), .req_sel(req_sel), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wen(req_wen),
        .grant(grant), .q_data(q_data), .busy(busy), .err(err),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wen(s_wen), .s_q(s_q),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .out_addr(out_addr), .out_wdata(out_wdata), .out_wen(out_wen)
    );

    // memories: 1-cycle read latency; ROM content is 8'h30 + address
    always @(posedge clk) begin
        if (s_wen) s_mem[s_addr] <= s_wdata;
        s_q   <= s_mem[s_addr];
        rom_q <= 8'h30 + {3'b000, rom_addr};
        if (out_wen) out_mem[out_addr] <= out_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model: check this cycle's outputs, then advance to the next cycle
    always @(negedge clk) begin
        logic [1:0] sel;
        logic [7:0] a, d;
        logic       w;
        bit         act, bad, intr, viol;
        logic [7:0] eq;
        sel = 2'd0; a = 8'd0; d = 8'd0; w = 1'b0; intr = 1'b0;
        act = (m_owner >= 0) && !reset;
        if (m_owner >= 0) begin
            sel = req_sel[2*m_owner +: 2];
            a   = req_addr[8*m_owner +: 8];
            d   = req_wdata[8*m_owner +: 8];
            w   = req_wen[m_owner];
        end
        for (int i = 0; i < NC; i++)
            if (i != m_owner && req_wen[i]) intr = 1'b1;
        bad  = (sel >= 2'd2) && (a >= 32);
        viol = act && ((sel == 2'd2 && w) || bad || intr);
        eq   = (m_seld == 2'd1) ? s_q : (m_seld == 2'd2) ? rom_q : 8'h00;

        chk("grant",     grant,     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("busy",      busy,      m_owner >= 0);
        chk("err",       err,       m_err);
        chk("s_wen",     s_wen,     act && sel == 2'd1 && w);
        chk("s_addr",    s_addr,    (act && sel == 2'd1) ? a : 8'd0);
        chk("s_wdata",   s_wdata,   (act && sel == 2'd1) ? d : 8'd0);
        chk("rom_addr",  rom_addr,  (act && sel == 2'd2 && !bad) ? a % 32 : 0);
        chk("out_addr",  out_addr,  (act && sel == 2'd3 && !bad) ? a % 32 : 0);
        chk("out_wdata", out_wdata, (act && sel == 2'd3 && !bad) ? d : 8'd0);
        chk("out_wen",   out_wen,   act && sel == 2'd3 && !bad && w);
        chk("q_data",    q_data,    eq);

        if (reset) begin
            m_owner = -1; m_gap = 0; m_err = 1'b0; m_seld = 2'd0;
        end else begin
            if (viol) m_err = 1'b1;
            m_seld = (act && !bad) ? sel : 2'd0;
            if (m_owner >= 0) begin
                if (!req_own[m_owner]) begin m_owner = -1; m_gap = 1; end
            end else if (m_gap > 0) begin
                m_gap--;
            end else begin
                for (int i = NC - 1; i >= 0; i--)
                    if (req_own[i]) m_owner = i;
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic drv(input int c, input bit own, input logic [1:0] sel,
                       input logic [7:0] addr, input logic [7:0] wd, input bit wen);
        req_own[c]          = own;
        req_sel[2*c +: 2]   = sel;
        req_addr[8*c +: 8]  = addr;
        req_wdata[8*c +: 8] = wd;
        req_wen[c]          = wen;
    endtask

    initial begin
        reset = 1'b1;
        req_own = '0; req_wen = '0; req_sel = '0; req_addr = '0; req_wdata = '0;
        cyc(); cyc();
        reset = 1'b0;

        // client 2 takes ownership
        drv(2, 1, 2'd0, 8'h00, 8'h00, 0); #1;
        chk("grant_c0", grant, 3'b000);
        chk("wen_c0", {s_wen, out_wen}, 2'b00);
        cyc();
        chk("grant_c1", grant, 3'b100);
        chk("busy_c1", busy, 1'b1);

        // S write then read back, then ROM read
        drv(2, 1, 2'd1, 8'h05, 8'hA7, 1); #1;
        chk("s_write_wen", s_wen, 1'b1);
        chk("s_write_addr", s_addr, 8'h05);
        chk("s_write_data", s_wdata, 8'hA7);
        cyc(); drv(2, 1, 2'd1, 8'h05, 8'h00, 0);
        cyc(); drv(2, 1, 2'd2, 8'h03, 8'h00, 0); #1;
        chk("q_s_read", q_data, 8'hA7);
        cyc(); drv(2, 1, 2'd0, 8'h00, 8'h00, 0); #1;
        chk("q_rom_read", q_data, 8'h33);
        chk("err_clean", err, 1'b0);

        // write to ROM is dropped and flags err
        cyc(); drv(2, 1, 2'd2, 8'h03, 8'hFF, 1); #1;
        chk("rom_wr_swen", s_wen, 1'b0);
        chk("rom_wr_owen", out_wen, 1'b0);
        cyc(); drv(2, 1, 2'd0, 8'h00, 8'h00, 0); #1;
        chk("err_set", err, 1'b1);
        repeat (3) cyc();
        chk("err_sticky", err, 1'b1);
        drv(2, 0, 2'd0, 8'h00, 8'h00, 0);
        cyc(); cyc(); cyc();

        // clear, then simultaneous requests from clients 0 and 1
        reset = 1'b1; cyc(); reset = 1'b0; #1;
        chk("err_cleared", err, 1'b0);
        drv(0, 1, 2'd0, 8'h00, 8'h00, 0);
        drv(1, 1, 2'd0, 8'h00, 8'h00, 0);
        cyc();
        chk("grant_prio", grant, 3'b001);
        drv(0, 1, 2'd3, 8'd31, 8'h5C, 1); #1;
        chk("out_wen_ok", out_wen, 1'b1);
        chk("out_addr_ok", out_addr, 5'd31);
        chk("out_wdata_ok", out_wdata, 8'h5C);
        cyc(); drv(0, 1, 2'd3, 8'd40, 8'h11, 1); #1;
        chk("oob_wen", out_wen, 1'b0);
        chk("oob_err_pre", err, 1'b0);
        cyc(); drv(0, 1, 2'd0, 8'h00, 8'h00, 0); #1;
        chk("oob_err", err, 1'b1);
        chk("out_mem31", out_mem[31], 8'h5C);

        // client 0 drops own; handover to client 1 after the quiet gap
        cyc(); drv(0, 0, 2'd0, 8'h00, 8'h00, 0); #1;
        chk("drop_cycle_grant", grant, 3'b001);
        cyc(); drv(0, 0, 2'd1, 8'h10, 8'hEE, 1); #1;
        chk("release_grant", grant, 3'b000);
        chk("release_busy", busy, 1'b0);
        chk("release_wen", s_wen, 1'b0);
        cyc(); drv(0, 0, 2'd0, 8'h00, 8'h00, 0); #1;
        chk("idle_gap", grant, 3'b000);
        cyc();
        chk("handover", grant, 3'b010);

        // reset while client 1 is writing S
        drv(1, 1, 2'd1, 8'h09, 8'h44, 1); #1;
        chk("c1_write", s_wen, 1'b1);
        reset = 1'b1; #1;
        chk("reset_no_wen", s_wen, 1'b0);
        cyc();
        chk("reset_grant", grant, 3'b000);
        chk("reset_busy", busy, 1'b0);
        chk("reset_err", err, 1'b0);
        reset = 1'b0;
        drv(1, 1, 2'd0, 8'h00, 8'h00, 0);
        cyc(); #1;
        chk("regrant", grant, 3'b010);

        // non-owner write is ignored but flagged
        drv(2, 0, 2'd1, 8'h20, 8'h99, 1); #1;
        chk("intruder_ignored", s_wen, 1'b0);
        cyc(); drv(2, 0, 2'd0, 8'h00, 8'h00, 0); #1;
        chk("intruder_err", err, 1'b1);
        drv(1, 0, 2'd0, 8'h00, 8'h00, 0);
        repeat (4) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rc4_mem_handler.md
Name: rc4_mem_handler

Overview:
- Responder side of the RC4 client memory-access interface: own, memory_sel, address, data, wen.
- Arbitrates up to NUM_CLIENTS client FSMs (S-init, key-schedule, decrypt) for exclusive ownership.
- Routes the owner's accesses to three memories: S RAM (256x8), encrypted-message ROM (32x8), decrypted-output RAM (32x8).
- Returns read data on a shared q_data bus.

Parameters:
- NUM_CLIENTS, 3, number of requesting FSMs; index 0 has highest priority.
- MSG_DEPTH, 32, depth of the ROM and output RAM; addresses at or above it are illegal for sel 2/3.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_own  in  NUM_CLIENTS  per-client ownership request (held high for the whole session)
- req_sel  in  2*NUM_CLIENTS  per-client memory_sel: 0 none, 1 S, 2 ROM, 3 output
- req_addr  in  8*NUM_CLIENTS  per-client address
- req_wdata  in  8*NUM_CLIENTS  per-client write data
- req_wen  in  NUM_CLIENTS  per-client write enable
- grant  out  NUM_CLIENTS  one-hot current owner, registered
- q_data  out  8  read data returned to all clients
- busy  out  1  high while any client owns the memories
- err  out  1  sticky protocol-violation flag
- s_addr  out  8  S RAM address
- s_wdata  out  8  S RAM write data
- s_wen  out  1  S RAM write enable
- s_q  in  8  S RAM read data (1-cycle latency)
- rom_addr  out  5  ROM address
- rom_q  in  8  ROM read data (1-cycle latency)
- out_addr  out  5  output RAM address
- out_wdata  out  8  output RAM write data
- out_wen  out  1  output RAM write enable

Behaviour:
- Reset values: grant=0, busy=0, err=0, sel_d=0. All memory addresses, wdata and wens are 0; q_data=0. Reset mid-session drops the owner immediately; no write is issued in the reset cycle.
- State machine, three states:
  - IDLE -> OWNED when any req_own is high. The lowest set index wins. grant and busy are registered on that edge, so the grant appears 1 cycle after the request.
  - OWNED -> RELEASE when req_own of the owner goes low.
  - RELEASE -> IDLE unconditionally. RELEASE is a 1-cycle quiet gap; all wens are forced to 0 in it.
- Handover: a new owner is granted no earlier than 2 cycles after the previous owner drops own.
- Other clients raising own during OWNED wait; there is no preemption.
- Routing in OWNED only, combinational from the owner's req_* signals:
  - sel 1: s_addr=addr, s_wdata=wdata, s_wen=wen.
  - sel 2: rom_addr=addr[4:0]; wen is ignored.
  - sel 3: out_addr=addr[4:0], out_wdata=wdata, out_wen=wen.
  - Unselected memories get address 0 and wen 0.
- Read return:
  - sel_d is the owner's sel, registered every clock (0 outside OWNED).
  - q_data = s_q / rom_q / out_q-equivalent 0 per sel_d: s_q for 1, rom_q for 2, 0 for 3 (output RAM is write-only) and 0 for 0. The mux is combinational.
  - Net effect: data is valid in the second cycle after the client registers its address, matching the setup/read/sample pattern.
- err sets (sticky until reset) on any of:
  - wen with sel 2; the write is dropped.
  - sel 2/3 with addr >= MSG_DEPTH; the access is suppressed: wen 0, q returns 0.
  - A non-owner asserting req_wen while another client is granted; the write is ignored.
- Simultaneous owner drop and new request: RELEASE, then IDLE, then grant, following the state transitions above.

Decomposition:
- Package rc4_mem_pkg:
  - mem_sel_t enum: SEL_NONE=0, SEL_S=1, SEL_ROM=2, SEL_OUT=3.
  - handler state enum: IDLE, OWNED, RELEASE.
  - MSG_DEPTH constant (32).
- Sub-module: fixed_prio_arb, combinational lowest-index one-hot picker.
- The FSM, routing mux, sel_d register and err logic stay in rc4_mem_handler.

Test Plan:
- Client 2 raises own at cycle 0 -> grant=3'b100 and busy=1 from cycle 1; no memory wen before cycle 1.
- Owner writes sel 1, addr 8'h05, data 8'hA7 -> s_wen=1, s_addr=05, s_wdata=A7 that cycle. A subsequent read of addr 05 gives q_data=A7 two cycles after address registration.
- Clients 0 and 1 request in the same cycle -> grant=3'b001. Client 0 drops own at cycle 10 -> RELEASE at cycle 11 with wens 0, IDLE at 12, grant=3'b010 at 13.
- Owner issues sel 2 with wen=1, addr 3 -> no memory written, err=1 and err stays 1 until reset.
- Owner issues sel 3, addr 8'd40 -> out_wen=0, err=1. Owner issues sel 3, addr 31, data 8'h5C -> out_wen=1, out_addr=31, out_wdata=5C.
- Reset asserted while client 1 holds an S write -> same cycle edge: grant=0, s_wen=0, busy=0, err=0.
